// File: rtl/uart_rx_parity.sv
// UART receiver: 8 data bits LSB first, even parity, one stop bit, with a small
// receive FIFO carrying per-byte parity/framing flags and a sticky overflow flag.
//
// state     | meaning
// IDLE      | line idle, waiting for rxs=0
// START     | half a bit into the start bit, checking it is still low
// DATA      | sampling the 8 data bits, one per bit period
// PARITY    | sampling the parity bit
// STOP      | sampling the stop bit and pushing the byte
// WAIT_IDLE | stop bit was low, waiting for the line to return high
module uart_rx_parity #(
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             rx,
  input  logic [DIV_W-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_parity_err,
  output logic             out_frame_err,
  output logic             overflow,
  input  logic             overflow_clr
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(3);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, WAIT_IDLE
  } state_t;

  state_t           state, state_nxt;
  logic             rx_meta, rxs;
  logic [DIV_W-1:0] div_eff, div_lat, timer;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             par_err;
  logic             tc, start_det, sample, push, pop, accept;
  logic [9:0]       mem [FIFO_DEPTH];
  logic [9:0]       head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  assign div_eff = (divisor < DIV_MIN) ? DIV_MIN : divisor;
  assign tc      = (timer == '0);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!rxs) state_nxt = START;
      START:     if (tc) state_nxt = rxs ? IDLE : DATA;
      DATA:      if (tc && bit_idx == 3'd7) state_nxt = PARITY;
      PARITY:    if (tc) state_nxt = STOP;
      STOP:      if (tc) state_nxt = rxs ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (rxs) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start_det = 1'b0;
    sample    = 1'b0;
    push      = 1'b0;
    case (state)
      IDLE:                start_det = !rxs;
      START, DATA, PARITY: sample = tc;
      STOP: begin
        sample = tc;
        push   = tc;
      end
      default: ;
    endcase
  end

  // Bit timer counts down to the next sample point; the first one lands mid start bit.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      timer   <= '0;
      div_lat <= DIV_MIN;
      bit_idx <= '0;
      shreg   <= '0;
      par_err <= 1'b0;
    end else begin
      if (start_det) begin
        div_lat <= div_eff;
        timer   <= (div_eff >> 1) - DIV_W'(1);
      end else if (sample) begin
        timer <= div_lat - DIV_W'(1);
      end else if (state != IDLE && state != WAIT_IDLE) begin
        timer <= timer - DIV_W'(1);
      end
      if (sample) begin
        case (state)
          START:   bit_idx <= '0;
          DATA: begin
            shreg   <= {rxs, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end
          PARITY:  par_err <= ^{shreg, rxs};
          default: ;
        endcase
      end
    end
  end

  assign pop    = out_valid && out_ready;
  assign accept = push && ((count < CNT_W'(FIFO_DEPTH)) || pop);

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= {~rxs, par_err, shreg};
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
      case ({accept, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
      // A drop in the same cycle as a clear must leave the flag set.
      if (push && !accept)   overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  always_comb begin
    out_valid      = (count != '0);
    head           = out_valid ? mem[rd_ptr] : '0;
    out_data       = head[7:0];
    out_parity_err = head[8];
    out_frame_err  = head[9];
  end

endmodule

// File: tb/tb_uart_rx_parity.sv
// Bench for uart_rx_parity: directed frame table, multi-cycle corner sequences,
// and randomized frames checked against a frame-level scoreboard.
module tb_uart_rx_parity;
  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             nreset = 1'b0;
  logic             rx = 1'b1;
  logic [DIV_W-1:0] divisor = 16'd3;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [7:0]       out_data;
  logic             out_parity_err;
  logic             out_frame_err;
  logic             overflow;
  logic             overflow_clr = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc = 0;
  logic valid_q = 1'b0;
  bit sender_done = 1'b0;
  logic [9:0] exp_q[$];

  typedef struct {
    int         div_in;
    logic [7:0] d;
    logic       p;
    logic       stop;
    int         extra;
    logic [7:0] e_data;
    logic       e_perr;
    logic       e_ferr;
  } vec_t;
  vec_t tbl[10];

  uart_rx_parity #(.DIV_W(DIV_W), .FIFO_DEPTH(4)) dut (
    .clk(clk), .nreset(nreset), .rx(rx), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_parity_err(out_parity_err), .out_frame_err(out_frame_err),
    .overflow(overflow), .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (out_valid && !valid_q) rise_cyc = cyc;
    valid_q = out_valid;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int eff_div(input int div_in);
    return (div_in < 3) ? 3 : div_in;
  endfunction

  // Start edge to out_valid: two synchronizer flops, one cycle to leave IDLE,
  // half a bit to the start sample, then ten full bits to the stop sample.
  function automatic int exp_lat(input int div_in);
    return 3 + eff_div(div_in) / 2 + 10 * eff_div(div_in);
  endfunction

  function automatic logic [9:0] ref_entry(input logic [7:0] d, input logic p, input logic stop);
    return {~stop, (^d) ^ p, d};
  endfunction

  task automatic send_frame(input int div_in, input logic [7:0] d, input logic p,
                            input logic stop, input int extra_low, input int gap,
                            input bit scramble);
    int eff;
    logic [10:0] bits;
    eff  = eff_div(div_in);
    bits = {stop, p, d, 1'b0};
    @(negedge clk);
    divisor   = DIV_W'(div_in);
    start_cyc = cyc;
    for (int i = 0; i < 11; i++) begin
      rx = bits[i];
      if (scramble && i == 1) divisor = DIV_W'($urandom);
      repeat (eff + ((i == 10 && !stop) ? extra_low : 0)) @(negedge clk);
    end
    rx = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pop_one();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    bit ok;
    tbl[0] = '{3,  8'hA5, 1'b0, 1'b1, 0, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{3,  8'h01, 1'b0, 1'b1, 0, 8'h01, 1'b1, 1'b0};
    tbl[2] = '{3,  8'h3C, 1'b0, 1'b0, 2, 8'h3C, 1'b0, 1'b1};
    tbl[3] = '{3,  8'h55, 1'b0, 1'b1, 0, 8'h55, 1'b0, 1'b0};
    tbl[4] = '{0,  8'hC3, 1'b0, 1'b1, 0, 8'hC3, 1'b0, 1'b0};
    tbl[5] = '{1,  8'h80, 1'b1, 1'b1, 0, 8'h80, 1'b0, 1'b0};
    tbl[6] = '{7,  8'h7F, 1'b1, 1'b1, 0, 8'h7F, 1'b0, 1'b0};
    tbl[7] = '{4,  8'hFF, 1'b1, 1'b0, 0, 8'hFF, 1'b1, 1'b1};
    tbl[8] = '{16, 8'h96, 1'b0, 1'b1, 0, 8'h96, 1'b0, 1'b0};
    tbl[9] = '{5,  8'h00, 1'b0, 1'b1, 0, 8'h00, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, 8'h00);
    check("rst_perr", out_parity_err, 1'b0);
    check("rst_ferr", out_frame_err, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    nreset = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      send_frame(tbl[i].div_in, tbl[i].d, tbl[i].p, tbl[i].stop, tbl[i].extra, 6, 1'b0);
      wait_valid(250, ok);
      check("vec_valid", ok, 1'b1);
      #1;
      check("vec_latency", rise_cyc - start_cyc, exp_lat(tbl[i].div_in));
      check("vec_data", out_data, tbl[i].e_data);
      check("vec_perr", out_parity_err, tbl[i].e_perr);
      check("vec_ferr", out_frame_err, tbl[i].e_ferr);
      pop_one();
      check("vec_empty", out_valid, 1'b0);
    end

    // one-clock low glitch at divisor 16 must not produce a byte
    @(negedge clk);
    divisor = 16'd16;
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (60) @(negedge clk);
    check("glitch_no_entry", out_valid, 1'b0);
    send_frame(16, 8'h3A, 1'b0, 1'b1, 0, 4, 1'b0);
    wait_valid(250, ok);
    check("glitch_next_valid", ok, 1'b1);
    check("glitch_next_data", {out_frame_err, out_parity_err, out_data}, ref_entry(8'h3A, 1'b0, 1'b1));
    pop_one();

    // overflow: five bytes into a four-entry FIFO with no consumer
    for (int k = 0; k < 5; k++) begin
      logic [7:0] b;
      b = 8'h10 + 8'(k);
      send_frame(3, b, ^b, 1'b1, 0, 0, 1'b0);
    end
    repeat (20) @(negedge clk);
    check("ovf_set", overflow, 1'b1);
    check("ovf_head", out_data, 8'h10);
    @(negedge clk);
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    check("ovf_clr", overflow, 1'b0);
    // clear pulse coincides with a dropped push: the set must win
    fork
      send_frame(3, 8'h15, ^(8'h15), 1'b1, 0, 0, 1'b0);
      begin
        @(negedge clk);
        repeat (exp_lat(3) - 1) @(negedge clk);
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
      end
    join
    check("ovf_set_priority", overflow, 1'b1);
    for (int k = 0; k < 4; k++) begin
      check("ovf_order", out_data, 8'h10 + 8'(k));
      pop_one();
    end
    check("ovf_drained", out_valid, 1'b0);
    @(negedge clk);
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    check("ovf_clr2", overflow, 1'b0);

    // reset in the middle of data bit 4 with a byte waiting in the FIFO
    send_frame(3, 8'hA5, 1'b0, 1'b1, 0, 4, 1'b0);
    wait_valid(100, ok);
    check("mid_rst_pre_valid", ok, 1'b1);
    @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      repeat (3) @(negedge clk);
    end
    rx = 1'b0;
    @(negedge clk);
    nreset = 1'b0;
    rx = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_data", out_data, 8'h00);
    check("mid_rst_perr", out_parity_err, 1'b0);
    check("mid_rst_ferr", out_frame_err, 1'b0);
    check("mid_rst_ovf", overflow, 1'b0);
    repeat (3) @(negedge clk);
    nreset = 1'b1;
    repeat (40) @(negedge clk);
    check("mid_rst_no_entry", out_valid, 1'b0);
    send_frame(3, 8'h7E, 1'b0, 1'b1, 0, 4, 1'b0);
    wait_valid(100, ok);
    check("post_rst_valid", ok, 1'b1);
    check("post_rst_entry", {out_frame_err, out_parity_err, out_data}, {2'b00, 8'h7E});
    pop_one();
    check("post_rst_empty", out_valid, 1'b0);

    // randomized frames with a randomly stalling consumer
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          int dv;
          logic [7:0] d;
          logic p, st;
          dv = $urandom_range(0, 12);
          d  = 8'($urandom);
          p  = (^d) ^ ($urandom_range(0, 3) == 0);
          st = ($urandom_range(0, 7) != 0);
          exp_q.push_back(ref_entry(d, p, st));
          send_frame(dv, d, p, st, st ? 0 : $urandom_range(0, 4),
                     st ? $urandom_range(0, 3) : $urandom_range(2, 5), 1'b1);
        end
        sender_done = 1'b1;
      end
      begin
        int budget;
        logic [9:0] e;
        budget = 0;
        while (!(sender_done && exp_q.size() == 0) && budget < 20000) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 1) == 1);
          @(negedge clk);
          budget++;
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
              check("rand_unexpected", out_valid, 1'b0);
            end else begin
              e = exp_q.pop_front();
              check("rand_entry", {out_frame_err, out_parity_err, out_data}, e);
            end
          end
        end
        out_ready = 1'b0;
        check("rand_drained", exp_q.size(), 0);
      end
    join
    repeat (5) @(negedge clk);
    check("rand_final_empty", out_valid, 1'b0);
    check("rand_no_overflow", overflow, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
